// File: rtl/host_link_tx.sv
// host_link_tx: FIFO-buffered 32-bit word serializer, one MSB-first byte per 8-cycle frame, word byte 3 first.
// Define HOST_LINK_TX_SOF_EN to prefix each burst with SOF_BYTE.
`default_nettype none

module host_link_tx #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter logic [7:0] SOF_BYTE  = 8'hD5
) (
  input  logic        t_clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        full,
  output logic        overflow,
  output logic        byte_strb,
  output logic        busy,
  output logic [15:0] words_sent,
  output logic        data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd2;
`ifdef HOST_LINK_TX_SOF_EN
  localparam logic [1:0] S_SOF  = 2'd1;
`else
  logic [7:0] unused_sof_byte;
  assign unused_sof_byte = SOF_BYTE;
`endif

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q;
  logic [31:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [15:0]   words_sent_q;

  logic          boundary, empty, push, pop, sent_inc;
  logic [7:0]    next_byte, cur_byte;
  logic [1:0]    sel;
  logic [31:0]   head;

  assign boundary = (bit_cnt_q == 3'd7);
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign push     = wr_en && !full;
  assign head     = fifo_q[rd_ptr_q];

  // idx_q names the byte currently on the wire; the next one down is idx_q-1.
  assign sel      = idx_q - 2'd1;
  assign cur_byte = word_q[{sel, 3'b000} +: 8];

  assign data_out   = shreg_q[7];
  assign byte_strb  = (bit_cnt_q == 3'd0);
  assign busy       = (state_q != S_IDLE) || !empty;
  assign overflow   = overflow_q;
  assign words_sent = words_sent_q;

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
`ifdef HOST_LINK_TX_SOF_EN
            state_d = S_SOF;
`else
            state_d = S_DATA;
`endif
          end
        end
`ifdef HOST_LINK_TX_SOF_EN
        S_SOF:  state_d = S_DATA;
`endif
        S_DATA: begin
          if (idx_q == 2'd0 && empty) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    next_byte = IDLE_BYTE;
    pop       = 1'b0;
    idx_d     = idx_q;
    sent_inc  = 1'b0;
    if (boundary) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
`ifdef HOST_LINK_TX_SOF_EN
            next_byte = SOF_BYTE;
`else
            pop       = 1'b1;
            next_byte = head[31:24];
            idx_d     = 2'd3;
`endif
          end
        end
`ifdef HOST_LINK_TX_SOF_EN
        S_SOF: begin
          pop       = 1'b1;
          next_byte = head[31:24];
          idx_d     = 2'd3;
        end
`endif
        S_DATA: begin
          if (idx_q != 2'd0) begin
            next_byte = cur_byte;
            idx_d     = idx_q - 2'd1;
          end else begin
            sent_inc = 1'b1;
            // Back-to-back words chain straight into byte 3 with no gap slot.
            if (!empty) begin
              pop       = 1'b1;
              next_byte = head[31:24];
              idx_d     = 2'd3;
            end
          end
        end
        default: next_byte = IDLE_BYTE;
      endcase
    end
  end

  always_ff @(posedge t_clk) begin
    if (push) fifo_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      idx_q        <= 2'd0;
      word_q       <= 32'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      words_sent_q <= 16'h0;
    end else begin
      if (boundary) begin
        shreg_q   <= next_byte;
        bit_cnt_q <= 3'd0;
      end else begin
        shreg_q   <= {shreg_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      idx_q <= idx_d;
      if (pop) begin
        word_q   <= head;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && full) overflow_q <= 1'b1;
      if (sent_inc) words_sent_q <= words_sent_q + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_host_link_tx.sv
// tb_host_link_tx: randomized writes against a byte-slot level model of the serial link.
`default_nettype none

module tb_host_link_tx;

  localparam int         DEPTH  = 4;
  localparam logic [7:0] IDLE_B = 8'h3C;
  localparam logic [7:0] SOF_B  = 8'hD5;
`ifdef HOST_LINK_TX_SOF_EN
  localparam bit SOF_MODE = 1'b1;
`else
  localparam bit SOF_MODE = 1'b0;
`endif
  localparam int K_IDLE = 0, K_SOF = 1, K_DATA = 2, K_LAST = 3;

  logic        t_clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, overflow, byte_strb, busy, data_out;
  logic [15:0] words_sent;

  host_link_tx #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE_B), .SOF_BYTE(SOF_B)) dut (
    .t_clk(t_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .byte_strb(byte_strb), .busy(busy),
    .words_sent(words_sent), .data_out(data_out)
  );

  always #5 t_clk = ~t_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: what each 8-bit slot carries, decided at slot boundaries.
  logic [31:0] q [$];
  logic [7:0]  tx [$];
  int          pos;
  int          kind;
  logic [7:0]  cur;
  logic [15:0] sent;
  bit          ovf;
  logic [63:0] rx;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit m_busy();
    return (kind != K_IDLE) || (q.size() != 0);
  endfunction

  task automatic m_reset();
    q.delete(); tx.delete();
    pos = 0; kind = K_IDLE; cur = 8'h00; sent = 16'h0; ovf = 1'b0; rx = 64'h0;
  endtask

  task automatic m_edge(bit wr, logic [31:0] d);
    int pre;
    logic [31:0] w;
    pre = q.size();
    if (pos == 7) begin
      if (kind == K_LAST) sent = sent + 16'd1;
      if (tx.size() != 0) begin
        cur  = tx.pop_front();
        kind = (tx.size() == 0) ? K_LAST : K_DATA;
      end else if (q.size() != 0 && (!SOF_MODE || kind == K_LAST || kind == K_SOF)) begin
        w = q.pop_front();
        tx.push_back(w[23:16]); tx.push_back(w[15:8]); tx.push_back(w[7:0]);
        cur  = w[31:24];
        kind = K_DATA;
      end else if (q.size() != 0) begin
        cur  = SOF_B;
        kind = K_SOF;
      end else begin
        cur  = IDLE_B;
        kind = K_IDLE;
      end
      pos = 0;
    end else begin
      pos++;
    end
    if (wr) begin
      if (pre < DEPTH) q.push_back(d);
      else ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    check("data_out",   64'(data_out),   64'(cur[7-pos]));
    check("byte_strb",  64'(byte_strb),  64'(pos == 0));
    check("full",       64'(full),       64'(q.size() == DEPTH));
    check("busy",       64'(busy),       64'(m_busy()));
    check("overflow",   64'(overflow),   64'(ovf));
    check("words_sent", 64'(words_sent), 64'(sent));
    rx = {rx[62:0], data_out};
  endtask

  task automatic step(bit wr, logic [31:0] d);
    wr_en = wr; wr_data = d;
    @(posedge t_clk);
    m_edge(wr, d);
    @(negedge t_clk);
    wr_en = 1'b0;
    cyc++;
    check_all();
  endtask

  task automatic wait_pos(int p);
    for (int n = 0; n < 16 && pos != p; n++) step(1'b0, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy() && n < 400) begin step(1'b0, 32'h0); n++; end
    if (n >= 400) check("drain_timeout", 64'd1, 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] rw;
    rst = 1'b1; wr_en = 1'b0; wr_data = 32'h0;
    m_reset();
    repeat (3) @(negedge t_clk);
    check_all();
    rst = 1'b0;
    m_reset();
    check_all();

    // Single word written during cycle 3.
    repeat (3) step(1'b0, 32'h0);
    step(1'b1, 32'hA1B2C3D4);
    while (cyc < (SOF_MODE ? 47 : 39)) step(1'b0, 32'h0);
    check("single_stream", rx, SOF_MODE ? 64'h00D5A1B2C3D4 : 64'h00A1B2C3D4);
    check("single_ws_before", 64'(words_sent), 64'd0);
    step(1'b0, 32'h0);
    check("single_ws_after", 64'(words_sent), 64'd1);
    check("single_idle", 64'(busy), 64'd0);

    // Fill the FIFO back-to-back, then overflow with DEADBEEF.
    wait_pos(0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom);
    check("fill_full", 64'(full), 64'd1);
    step(1'b1, 32'hDEADBEEF);
    check("ovf_set", 64'(overflow), 64'd1);
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("fill_ws", 64'(words_sent), 64'd5);

    // Write on the same edge as a slot boundary: one idle slot first.
    wait_pos(7);
    rw = $urandom;
    step(1'b1, rw);
    repeat (7) step(1'b0, 32'h0);
    check("race_idle_slot", 64'(rx[7:0]), 64'(IDLE_B));
    repeat (8) step(1'b0, 32'h0);
    check("race_next_slot", 64'(rx[7:0]), 64'(SOF_MODE ? SOF_B : rw[31:24]));
    drain();

    // Random traffic at light, medium and saturating write rates.
    for (int ph = 0; ph < 3; ph++) begin
      int p;
      p = (ph == 0) ? 15 : (ph == 1) ? 50 : 95;
      repeat (500) step($urandom_range(0, 99) < p, $urandom);
    end
    drain();

    // Reset in the middle of byte 2 with more words pending.
    wait_pos(0);
    step(1'b1, 32'h12FF3456);
    step(1'b1, $urandom);
    step(1'b1, $urandom);
    repeat (16 + (SOF_MODE ? 8 : 0)) step(1'b0, 32'h0);
    check("pre_rst_bit", 64'(data_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_data_out",   64'(data_out),   64'd0);
    check("rst_full",       64'(full),       64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_words_sent", 64'(words_sent), 64'd0);
    check("rst_overflow",   64'(overflow),   64'd0);
    check("rst_byte_strb",  64'(byte_strb),  64'd1);
    m_reset();
    repeat (2) @(negedge t_clk);
    rst = 1'b0;
    m_reset();
    check_all();
    repeat (7) step(1'b0, 32'h0);
    check("restart_slot", 64'(rx[7:0]), 64'h00);
    repeat (300) step($urandom_range(0, 99) < 40, $urandom);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
